// File: rtl/parallelism_deserializer.sv
// Gathers RATIO consecutive narrow input beats into one registered wide output beat.
// Short frames (data_in_last before the buffer fills) are flushed early with a keep mask.
module parallelism_deserializer #(
  parameter int                    DATA_WIDTH           = 8,
  parameter int                    DATA_IN_PARALLELISM  = 1,
  parameter int                    DATA_OUT_PARALLELISM = 4,
  parameter logic [DATA_WIDTH-1:0] PAD_VALUE            = '0
) (
  input  logic                                                clk,
  input  logic                                                rst,
  input  logic [DATA_WIDTH*DATA_IN_PARALLELISM-1:0]           data_in,
  input  logic                                                data_in_valid,
  input  logic                                                data_in_last,
  output logic                                                data_in_ready,
  output logic [DATA_WIDTH*DATA_OUT_PARALLELISM-1:0]          data_out,
  output logic [DATA_OUT_PARALLELISM/DATA_IN_PARALLELISM-1:0] data_out_keep,
  output logic                                                data_out_last,
  output logic                                                data_out_valid,
  input  logic                                                data_out_ready
);

  localparam int RATIO   = DATA_OUT_PARALLELISM / DATA_IN_PARALLELISM;
  localparam int CNT_W   = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int CHUNK_W = DATA_WIDTH * DATA_IN_PARALLELISM;
  localparam int OUT_W   = DATA_WIDTH * DATA_OUT_PARALLELISM;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(RATIO - 1);
  localparam logic [OUT_W-1:0] PAD_VEC  = {DATA_OUT_PARALLELISM{PAD_VALUE}};

  if ((DATA_OUT_PARALLELISM % DATA_IN_PARALLELISM) != 0 || RATIO < 2) begin : g_bad_ratio
    $error("parallelism_deserializer: OUT must be an integer multiple >= 2 of IN");
  end

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [OUT_W-1:0] acc_q, acc_d;
  logic [OUT_W-1:0] out_data_q, out_data_d;
  logic [RATIO-1:0] out_keep_q, out_keep_d;
  logic             out_last_q, out_last_d;
  logic             out_valid_q, out_valid_d;

  logic             cnt_at_end;
  logic             in_fire;
  logic             out_fire;
  logic             completing;
  logic [OUT_W-1:0] merged;
  logic [RATIO-1:0] keep_new;

  assign cnt_at_end = (cnt_q == LAST_CNT);
  assign completing = cnt_at_end || data_in_last;

  // Partial chunks never need the output register, so only a completing chunk can stall.
  assign data_in_ready = (!cnt_at_end && !data_in_last) || !out_valid_q || data_out_ready;
  assign in_fire       = data_in_valid && data_in_ready;
  assign out_fire      = out_valid_q && data_out_ready;

  // NOTE: every variable written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    merged   = acc_q;
    keep_new = '0;
    for (int k = 0; k < RATIO; k++) begin
      if (CNT_W'(k) == cnt_q) begin
        merged[k*CHUNK_W +: CHUNK_W] = data_in;
      end
      keep_new[k] = (CNT_W'(k) <= cnt_q);
    end
  end

  always_comb begin
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    out_data_d  = out_data_q;
    out_keep_d  = out_keep_q;
    out_last_d  = out_last_q;
    out_valid_d = out_valid_q;

    if (out_fire) begin
      out_valid_d = 1'b0;
    end

    if (in_fire) begin
      if (completing) begin
        out_data_d  = merged;
        out_keep_d  = keep_new;
        out_last_d  = data_in_last;
        out_valid_d = 1'b1;
        acc_d       = PAD_VEC;
        cnt_d       = '0;
      end else begin
        acc_d = merged;
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only; the buffer is reset too so
  // lanes left unfilled by a short frame always carry PAD_VALUE rather than stale data.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      acc_q       <= PAD_VEC;
      out_data_q  <= PAD_VEC;
      out_keep_q  <= '0;
      out_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      out_data_q  <= out_data_d;
      out_keep_q  <= out_keep_d;
      out_last_q  <= out_last_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign data_out       = out_data_q;
  assign data_out_keep  = out_keep_q;
  assign data_out_last  = out_last_q;
  assign data_out_valid = out_valid_q;

endmodule
